// File: rtl/uart_rx_controller.sv
// uart_rx_controller: UART receive sequencer clocked by a 16x oversample tick.
// Synchronises the serial line, validates the start bit at mid-bit, samples
// data bits LSB first at mid-bit, checks the stop bit and hands each byte to
// the consumer through a valid/ready output register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for a low sample on a tick
// START     | counting to mid start bit; high there means a glitch
// DATA      | sampling DATA_BITS data bits, one per OVERSAMPLE ticks
// STOP      | sampling the stop bit; high delivers, low flags frame_err
// WAIT_IDLE | after a framing error, hold until the line returns high

module uart_rx_controller #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oversample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // Synchroniser
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // Sequencer
  logic [2:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  // Output register
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;

  // Frame-completion strobes from the sequencer to the output register
  logic stop_ok;
  logic stop_bad;
  logic accept;

  // Two-flop synchroniser; the line idles high so both stages reset to 1.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // Frame sequencer: next state, tick/bit counters and the data shifter.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (oversample_tick && !rx_s_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end

      ST_START: begin
        if (oversample_tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            if (!rx_s_q) begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              // Line went back high before mid start bit: treat as noise.
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      ST_DATA: begin
        if (oversample_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      ST_STOP: begin
        if (oversample_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              stop_ok = 1'b1;
              state_d = ST_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = ST_WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Checked every clock so a long break cannot re-trigger a start.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Output register: deliver on a good stop bit, flag overrun if the previous
  // byte is still held, clear valid on handshake.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = stop_bad;
    overrun_err_d = 1'b0;
    accept        = rx_valid_q && rx_ready;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (stop_ok) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  // Output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed bench for uart_rx_controller.
// Ticks every 4 clk, so one bit is 64 clk. Inputs change 1 ns after posedge;
// outputs are checked 1 ns after posedge and monitored on negedge.

module tb_uart_rx_controller;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       oversample_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int total;
  int bad;

  int fe_cnt;
  int ov_cnt;
  int vld_cnt;
  logic [7:0] acc_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .oversample_tick (oversample_tick),
    .rx              (rx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .frame_err       (frame_err),
    .overrun_err     (overrun_err),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock tick every fourth clock.
  initial begin
    int tcnt;
    tcnt = 0;
    oversample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      oversample_tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  // Pulse counters and handshake log.
  initial begin
    fe_cnt  = 0;
    ov_cnt  = 0;
    vld_cnt = 0;
    forever begin
      @(negedge clk);
      if (frame_err)   fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (rx_valid)    vld_cnt++;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BIT_CLKS);
    end
    rx = stop;
    step(BIT_CLKS);
    rx = 1'b1;
    step(idle);
  endtask

  task automatic accept_one();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, vl0, acc0;
    bit hit;

    total = 0;
    bad   = 0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_fe: 0};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_fe: 0};
    vecs[2] = '{data: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h3C, exp_fe: 1};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_fe: 0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_fe: 0};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};

    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun_err", overrun_err, 0);
    check("reset busy", busy, 0);
    step(20);

    // Table of single frames received with rx_ready low, then accepted.
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[v].data, vecs[v].stop, 16);
      check("vec rx_valid", rx_valid, vecs[v].exp_valid);
      check("vec rx_data", rx_data, vecs[v].exp_data);
      check("vec frame_err pulses", fe_cnt - fe0, vecs[v].exp_fe);
      check("vec overrun pulses", ov_cnt - ov0, 0);
      check("vec busy", busy, 0);
      step(50);
      check("vec rx_valid held", rx_valid, vecs[v].exp_valid);
      check("vec rx_data held", rx_data, vecs[v].exp_data);
      if (vecs[v].exp_valid) begin
        accept_one();
        check("vec valid cleared", rx_valid, 0);
      end
      step(16);
    end

    // False start: 4 ticks low then high.
    fe0 = fe_cnt;
    rx = 1'b0;
    step(12);
    check("glitch busy in start", busy, 1);
    step(4);
    rx = 1'b1;
    step(BIT_CLKS);
    check("glitch busy after", busy, 0);
    check("glitch rx_valid", rx_valid, 0);
    check("glitch frame_err", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, 16);
    check("post glitch valid", rx_valid, 1);
    check("post glitch data", rx_data, 8'h3C);
    accept_one();
    step(16);

    // Break: bad stop bit, line held low well past the frame.
    fe0 = fe_cnt;
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(BIT_CLKS);
    end
    rx = 1'b0;
    step(4 * BIT_CLKS);
    check("break frame_err once", fe_cnt - fe0, 1);
    check("break busy held", busy, 1);
    check("break rx_valid", rx_valid, 0);
    rx = 1'b1;
    step(16);
    check("break busy released", busy, 0);
    send_frame(8'h81, 1'b1, 16);
    check("post break valid", rx_valid, 1);
    check("post break data", rx_data, 8'h81);
    check("post break no new fe", fe_cnt - fe0, 1);
    accept_one();
    step(16);

    // Overrun: second byte arrives while first still held.
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 16);
    check("ovr first valid", rx_valid, 1);
    check("ovr first data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 16);
    check("ovr data kept", rx_data, 8'h11);
    check("ovr valid kept", rx_valid, 1);
    check("ovr pulse once", ov_cnt - ov0, 1);
    acc0 = acc_q.size();
    accept_one();
    check("ovr valid cleared", rx_valid, 0);
    check("ovr accept count", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("ovr accepted byte", acc_q[acc0], 8'h11);
    step(16);

    // Same pair, but rx_ready rises exactly in the stop-sample cycle.
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 16);
    check("ready-hit first data", rx_data, 8'h11);
    acc0 = acc_q.size();
    hit = 1'b0;
    fork
      send_frame(8'h22, 1'b1, 16);
      begin
        for (int n = 0; n < 1200 && !hit; n++) begin
          @(posedge clk);
          #2;
          if (dut.state_q == 3'd3 && dut.tick_cnt_q == 4'd15 && oversample_tick) begin
            rx_ready = 1'b1;
            hit = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
          end
        end
      end
    join
    check("ready-hit window found", hit, 1);
    check("ready-hit data", rx_data, 8'h22);
    check("ready-hit valid", rx_valid, 1);
    check("ready-hit no overrun", ov_cnt - ov0, 0);
    check("ready-hit old accepted", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("ready-hit old byte", acc_q[acc0], 8'h11);
    accept_one();
    step(16);

    // Reset in the middle of the data bits with a byte pending.
    send_frame(8'h5A, 1'b1, 16);
    check("pre-reset valid", rx_valid, 1);
    rx = 1'b0;
    step(BIT_CLKS);
    rx = 1'b1; step(BIT_CLKS);
    rx = 1'b0; step(BIT_CLKS);
    rx = 1'b1; step(BIT_CLKS / 2);
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rx  = 1'b1;
    check("mid reset rx_valid", rx_valid, 0);
    check("mid reset rx_data", rx_data, 0);
    check("mid reset busy", busy, 0);
    check("mid reset frame_err", frame_err, 0);
    check("mid reset overrun", overrun_err, 0);
    fe0 = fe_cnt;
    step(2 * BIT_CLKS);
    check("post reset idle", busy, 0);
    check("post reset no fe", fe_cnt - fe0, 0);
    send_frame(8'hF0, 1'b1, 16);
    check("post reset valid", rx_valid, 1);
    check("post reset data", rx_data, 8'hF0);
    accept_one();
    step(16);

    // Back-to-back frames consumed immediately.
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    vl0  = vld_cnt;
    acc0 = acc_q.size();
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h7E, 1'b1, 16);
    rx_ready = 1'b0;
    check("b2b valid cycles", vld_cnt - vl0, 3);
    check("b2b accepted", acc_q.size() - acc0, 3);
    if (acc_q.size() >= acc0 + 3) begin
      check("b2b byte0", acc_q[acc0], 8'h00);
      check("b2b byte1", acc_q[acc0 + 1], 8'hFF);
      check("b2b byte2", acc_q[acc0 + 2], 8'h7E);
    end
    check("b2b no fe", fe_cnt - fe0, 0);
    check("b2b no overrun", ov_cnt - ov0, 0);
    check("b2b valid low", rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
